// File: rtl/pio_h2f_rmw_arbiter.sv
// Round-robin arbiter serialising masked read-modify-write updates of the
// HPS-to-FPGA PIO output register on behalf of NUM_REQ fabric requesters.
module pio_h2f_rmw_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] mask,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [1:0]                avm_address,
    output logic                      avm_chipselect,
    output logic                      avm_write_n,
    output logic [31:0]               avm_writedata,
    input  logic [31:0]               avm_readdata
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        ACK
    } state_t;

    state_t            state, state_n;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     pick;
    logic [GW-1:0]     cand;
    logic              found;
    logic [DATA_W-1:0] mask_l;
    logic [DATA_W-1:0] wdata_l;
    logic [DATA_W-1:0] new_val;
    logic [DATA_W-1:0] merged;

    assign avm_address = 2'b00;

    // Cyclic search starting one past the last granted requester.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = GW'((32'(last_grant) + 32'd1 + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // The value read is merged straight into the registered write data, so
    // the READ capture and the WRITE drive share one edge.
    assign merged = (avm_readdata[DATA_W-1:0] & ~mask_l) | (wdata_l & mask_l);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (found) state_n = READ;
            READ:    state_n = WRITE;
            WRITE:   state_n = ACK;
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= GW'(NUM_REQ - 1);
            grant          <= '0;
            mask_l         <= '0;
            wdata_l        <= '0;
            new_val        <= '0;
            ack            <= '0;
            rdata          <= '0;
            busy           <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
        end else begin
            state          <= state_n;
            busy           <= (state_n != IDLE);
            avm_chipselect <= (state_n == READ) || (state_n == WRITE);
            avm_write_n    <= (state_n != WRITE);
            ack            <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant   <= pick;
                        mask_l  <= mask[pick*DATA_W +: DATA_W];
                        wdata_l <= wdata[pick*DATA_W +: DATA_W];
                    end
                end
                READ: begin
                    new_val       <= merged;
                    avm_writedata <= 32'(merged);
                end
                WRITE: begin
                    ack   <= NUM_REQ'(1) << grant;
                    rdata <= new_val;
                end
                ACK: begin
                    last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_h2f_rmw_arbiter.sv
// Scoreboard bench for pio_h2f_rmw_arbiter with a behavioural PIO register.
module tb_pio_h2f_rmw_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*W-1:0] mask;
    logic [N*W-1:0] wdata;
    logic [N-1:0]  ack;
    logic [W-1:0]  rdata;
    logic          busy;
    logic [1:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata;

    logic [7:0]    pio;
    logic          pio_load;
    logic [7:0]    pio_load_val;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] val;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    logic [3:0] prev_ack = '0;

    pio_h2f_rmw_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .mask(mask),
        .wdata(wdata),
        .ack(ack),
        .rdata(rdata),
        .busy(busy),
        .avm_address(avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    // PIO s1 slave: zero-latency read, write on the strobe edge.
    assign avm_readdata = {24'h0, pio};
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (pio_load) pio <= pio_load_val;
        else if (avm_chipselect && !avm_write_n) pio <= avm_writedata[7:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: checks each write against the head of the scoreboard, pops on ack.
    always @(negedge clk) begin
        if (!reset) begin
            if (avm_chipselect && !avm_write_n) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got %h expected none", avm_writedata);
                end else begin
                    chk("writedata", avm_writedata, {24'h0, sbq[0].val});
                end
            end
            if (ack != '0) begin
                chk("ack_pulse_width", {28'h0, prev_ack & ack}, 32'h0);
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack: got %b expected none", ack);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("ack_onehot", {28'h0, ack}, {28'h0, mon_e.ack});
                    chk("rdata", {24'h0, rdata}, {24'h0, mon_e.val});
                    chk("pio_matches_rdata", {24'h0, pio}, {24'h0, mon_e.val});
                end
            end
        end
        prev_ack = ack;
    end

    task automatic issue(input int i, input logic [7:0] m, input logic [7:0] d, input logic [7:0] expv);
        exp_t e;
        mask[i*W +: W]  = m;
        wdata[i*W +: W] = d;
        req[i]          = 1'b1;
        e.ack = 4'b0001 << i;
        e.val = expv;
        sbq.push_back(e);
    endtask

    task automatic wait_ack(input int idx, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ack[idx] && cyc < 20);
        if (!ack[idx]) begin
            total++; bad++;
            $display("FAIL timeout_ack%0d: got no ack expected ack within 20 cycles", idx);
        end
    endtask

    task automatic wait_any(output logic [3:0] a);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (ack == '0 && c < 20);
        a = ack;
        if (ack == '0) begin
            total++; bad++;
            $display("FAIL timeout_any_ack: got no ack expected ack within 20 cycles");
        end
    endtask

    task automatic set_pio(input logic [7:0] v);
        pio_load_val = v;
        pio_load     = 1'b1;
        @(posedge clk);
        #1 pio_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs"},    {31'h0, avm_chipselect}, 32'h0);
        chk({tag, "_wn"},    {31'h0, avm_write_n},    32'h1);
        chk({tag, "_ack"},   {28'h0, ack},            32'h0);
        chk({tag, "_busy"},  {31'h0, busy},           32'h0);
        chk({tag, "_rdata"}, {24'h0, rdata},          32'h0);
        chk({tag, "_wdata"}, avm_writedata,           32'h0);
        chk({tag, "_addr"},  {30'h0, avm_address},    32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int last_t;
        logic [3:0] a;

        reset = 1'b1; req = '0; mask = '0; wdata = '0;
        pio_load = 1'b1; pio_load_val = 8'h00;
        @(posedge clk); @(posedge clk);
        #1 pio_load = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Requester 0, low nibble update from 0x00.
        issue(0, 8'h0F, 8'hA5, 8'h05);
        wait_ack(0, cyc);
        chk("t1_latency", cyc, 3);
        chk("t1_busy_in_ack", {31'h0, busy}, 32'h1);
        req[0] = 1'b0;
        @(negedge clk);
        chk("t1_ack_clear", {28'h0, ack}, 32'h0);

        // Requester 2, high nibble update; low nibble preserved.
        issue(2, 8'hF0, 8'h3C, 8'h35);
        wait_ack(2, cyc);
        chk("t2_latency", cyc, 3);
        req[2] = 1'b0;
        @(negedge clk);

        // All four requesting after reset: rotation 0,1,2,3 every 4 cycles.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        issue(0, 8'h03, 8'h00, 8'h34);
        issue(1, 8'h0C, 8'hFF, 8'h3C);
        issue(2, 8'h30, 8'h10, 8'h1C);
        issue(3, 8'hC0, 8'h80, 8'h9C);
        last_t = 0;
        for (int k = 0; k < 4; k++) begin
            wait_any(a);
            chk("t3_order", {28'h0, a}, 32'h1 << k);
            chk("t3_busy", {31'h0, busy}, 32'h1);
            if (k > 0) chk("t3_spacing", cyc_cnt - last_t, 4);
            last_t = cyc_cnt;
            req = req & ~a;
        end
        @(negedge clk);

        // Requester 1 changes inputs and drops req during READ.
        issue(1, 8'h0F, 8'h05, 8'h95);
        @(negedge clk);
        chk("t4_read_phase", {30'h0, avm_chipselect, avm_write_n}, 32'h3);
        mask[15:8]  = 8'hFF;
        wdata[15:8] = 8'hFF;
        req[1]      = 1'b0;
        wait_ack(1, cyc);
        chk("t4_latency", cyc, 2);
        @(negedge clk);

        // Empty mask rewrites the unchanged value.
        set_pio(8'h5A);
        issue(3, 8'h00, 8'hFF, 8'h5A);
        wait_ack(3, cyc);
        chk("t5_latency", cyc, 3);
        req[3] = 1'b0;
        @(negedge clk);

        // Reset during WRITE: abandon the transaction, no PIO write.
        set_pio(8'h11);
        mask[7:0] = 8'hFF; wdata[7:0] = 8'h77; req[0] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("t6_write_phase", {30'h0, avm_chipselect, avm_write_n}, 32'h2);
        reset = 1'b1;
        #1;
        chk_reset_outputs("t6_abort");
        req = '0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_no_write", {24'h0, pio}, 32'h11);
        reset = 1'b0;
        @(negedge clk);

        // First request after reset goes to requester 0 ahead of 3.
        issue(0, 8'hF0, 8'hA0, 8'hA1);
        issue(3, 8'h0F, 8'h0C, 8'hAC);
        wait_any(a);
        chk("t6_first_grant", {28'h0, a}, 32'h1);
        req = req & ~a;
        wait_any(a);
        chk("t6_second_grant", {28'h0, a}, 32'h8);
        req = req & ~a;
        @(negedge clk);
        @(negedge clk);

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
